// File: rtl/sdram_wb_arbiter_pkg.sv
// Shared state encodings and master ids for the SDRAM Wishbone arbiter.
package sdram_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/sdram_arb_rr.sv
// 2-way round-robin picker; purely combinational, zero latency.
// A tie goes to the master that was not granted last; a lone requester always wins.
module sdram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last : req[1];

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the SDRAM slave; grant visible one edge after request.
// Losing master waits; the grant holds until s_ack_i (or watchdog with SDRAM_ARB_WDT_EN), then one idle GAP cycle.
module sdram_wb_arbiter
  import sdram_wb_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int WDT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i
);

  state_t state;
  logic   last_grant;
  logic   bus_q;
  logic   m0_req, m1_req;
  logic   gnt_valid, gnt_id;
  logic   timeout;
  logic   in_gnt;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;
  assign in_gnt = (state == ST_GNT);

  sdram_arb_rr u_rr (
    .req       ({m1_req, m0_req}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef SDRAM_ARB_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  logic [WW-1:0] wdt;

  // The counter sits at zero outside GNT, so it is cleared on every grant entry.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)      wdt <= '0;
    else if (in_gnt) wdt <= wdt + 1'b1;
    else             wdt <= '0;
  end

  assign timeout = in_gnt && !s_ack_i && (wdt == WDT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= M1;
      bus_q      <= 1'b0;
      s_we_o     <= 1'b0;
      s_sel_o    <= '0;
      s_adr_o    <= '0;
      s_dat_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt_id;
            bus_q      <= 1'b1;
            s_we_o     <= gnt_id ? m1_we_i  : m0_we_i;
            s_sel_o    <= gnt_id ? m1_sel_i : m0_sel_i;
            s_adr_o    <= gnt_id ? m1_adr_i : m0_adr_i;
            s_dat_o    <= gnt_id ? m1_dat_i : m0_dat_i;
            state      <= ST_GNT;
          end
        end
        ST_GNT: begin
          if (s_ack_i || timeout) begin
            bus_q <= 1'b0;
            state <= ST_GAP;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: begin
          bus_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_cyc_o = bus_q;
  assign s_stb_o = bus_q;

  // A master that abandoned its cycle gets neither ack nor err: the completion is an orphan.
  assign m0_ack_o = in_gnt && s_ack_i && (last_grant == M0) && m0_req;
  assign m1_ack_o = in_gnt && s_ack_i && (last_grant == M1) && m1_req;
  assign m0_err_o = timeout && (last_grant == M0) && m0_req;
  assign m1_err_o = timeout && (last_grant == M1) && m1_req;
  assign m0_dat_o = m0_ack_o ? s_dat_i : '0;
  assign m1_dat_o = m1_ack_o ? s_dat_i : '0;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter; the watchdog section runs only when SDRAM_ARB_WDT_EN is defined.
module tb_sdram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat, m0_rdat;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_wb_arbiter #(.AW(32), .DW(32), .WDT_CYCLES(8)) dut (
    .wb_clk_i (clk),    .rst_n    (rst_n),
    .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we), .m0_sel_i (m0_sel),
    .m0_adr_i (m0_adr), .m0_dat_i (m0_dat), .m0_ack_o (m0_ack), .m0_dat_o (m0_rdat),
    .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we), .m1_sel_i (m1_sel),
    .m1_adr_i (m1_adr), .m1_dat_i (m1_dat), .m1_ack_o (m1_ack), .m1_dat_o (m1_rdat),
    .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc),  .s_stb_o  (s_stb),  .s_we_o  (s_we),  .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),  .s_dat_o  (s_wdat), .s_ack_i (s_ack), .s_dat_i  (s_rdat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_dat = dat;
  endtask

  task automatic req1(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_dat = dat;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_ack = 1'b0; s_rdat = '0;
    req0(1'b0, 1'b0, '0, '0);
    req1(1'b0, 1'b0, '0, '0);
    do_reset();
    #3;
    chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst_s_adr", s_adr, 32'd0);
    chk("rst_s_dat", s_wdat, 32'd0);
    chk("rst_acks",  {30'd0, m0_ack, m1_ack}, 32'd0);

    // T1: write, same-cycle ack, back-to-back from m0 shows the GAP.
    step(); req0(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF); #3;
    chk("t1_stb_before", {31'd0, s_stb}, 32'd0);
    step(); s_ack = 1'b1; #3;
    chk("t1_stb",  {30'd0, s_cyc, s_stb}, 32'd3);
    chk("t1_we",   {31'd0, s_we}, 32'd1);
    chk("t1_sel",  {28'd0, s_sel}, 32'hF);
    chk("t1_adr",  s_adr, 32'h0000_0010);
    chk("t1_dat",  s_wdat, 32'hDEAD_BEEF);
    chk("t1_ack0", {31'd0, m0_ack}, 32'd1);
    chk("t1_ack1", {31'd0, m1_ack}, 32'd0);
    step(); s_ack = 1'b0; #3;
    chk("t1_gap",  {31'd0, s_stb}, 32'd0);
    step(); #3;
    chk("t1_idle", {31'd0, s_stb}, 32'd0);
    step(); s_ack = 1'b1; #3;
    chk("t1_regrant", {31'd0, s_stb}, 32'd1);
    chk("t1_ack0_b",  {31'd0, m0_ack}, 32'd1);
    step(); s_ack = 1'b0; req0(1'b0, 1'b0, '0, '0); #3;
    step(); step();

    // T2: tie from reset goes to m0, then m1, then m0 again.
    do_reset();
    req0(1'b1, 1'b0, 32'h100, '0);
    req1(1'b1, 1'b0, 32'h200, '0);
    step(); #3;
    chk("t2_first_adr", s_adr, 32'h100);
    chk("t2_first_we",  {31'd0, s_we}, 32'd0);
    chk("t2_noack",     {30'd0, m0_ack, m1_ack}, 32'd0);
    step(); s_ack = 1'b1; s_rdat = 32'hAAAA_0000; #3;
    chk("t2_m0_ack",  {31'd0, m0_ack}, 32'd1);
    chk("t2_m0_dat",  m0_rdat, 32'hAAAA_0000);
    chk("t2_m1_ack",  {31'd0, m1_ack}, 32'd0);
    chk("t2_m1_dat",  m1_rdat, 32'd0);
    step(); s_ack = 1'b0; req0(1'b0, 1'b0, '0, '0); #3;
    step(); #3;
    chk("t2_gap_idle", {31'd0, s_stb}, 32'd0);
    step(); req0(1'b1, 1'b0, 32'h100, '0); s_ack = 1'b1; s_rdat = 32'h5555_5555; #3;
    chk("t2_second_adr", s_adr, 32'h200);
    chk("t2_m1_ack2",    {31'd0, m1_ack}, 32'd1);
    chk("t2_m1_dat2",    m1_rdat, 32'h5555_5555);
    chk("t2_m0_wait",    {31'd0, m0_ack}, 32'd0);
    chk("t2_m0_dat0",    m0_rdat, 32'd0);
    step(); s_ack = 1'b0; req1(1'b1, 1'b0, 32'h204, '0); #3;
    step(); #3;
    step(); s_ack = 1'b1; #3;
    chk("t2_third_adr", s_adr, 32'h100);
    chk("t2_m0_ack3",   {31'd0, m0_ack}, 32'd1);
    step(); s_ack = 1'b0; req0(1'b0, 1'b0, '0, '0); req1(1'b0, 1'b0, '0, '0); #3;
    step(); step();

    // T3: m1 read with a 6-cycle slave latency; latched address ignores master changes.
    step(); req1(1'b1, 1'b0, 32'h300, '0); #3;
    for (int i = 1; i <= 5; i++) begin
      step(); m1_adr = 32'hFFFF_0000 + i; #3;
      chk("t3_adr_hold", s_adr, 32'h300);
      chk("t3_no_ack",   {31'd0, m1_ack}, 32'd0);
    end
    step(); s_ack = 1'b1; s_rdat = 32'h1234_5678; #3;
    chk("t3_adr_last", s_adr, 32'h300);
    chk("t3_ack",      {31'd0, m1_ack}, 32'd1);
    chk("t3_dat",      m1_rdat, 32'h1234_5678);
    step(); s_ack = 1'b0; req1(1'b0, 1'b0, '0, '0); #3;
    step(); step();

    // T4: m0 abandons its read; the slave op still completes as an orphan, then m1 runs.
    step(); req0(1'b1, 1'b0, 32'h400, '0); #3;
    step(); #3;
    chk("t4_stb", {31'd0, s_stb}, 32'd1);
    step(); req0(1'b0, 1'b0, '0, '0); req1(1'b1, 1'b1, 32'h500, 32'hCAFE_F00D); #3;
    chk("t4_held", {31'd0, s_stb}, 32'd1);
    step(); #3;
    chk("t4_held_adr", s_adr, 32'h400);
    step(); s_ack = 1'b1; s_rdat = 32'h0BAD_0BAD; #3;
    chk("t4_orphan", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("t4_dat0",   m0_rdat, 32'd0);
    step(); s_ack = 1'b0; #3;
    chk("t4_gap", {31'd0, s_stb}, 32'd0);
    step(); #3;
    step(); s_ack = 1'b1; #3;
    chk("t4_m1_adr", s_adr, 32'h500);
    chk("t4_m1_dat", s_wdat, 32'hCAFE_F00D);
    chk("t4_m1_ack", {31'd0, m1_ack}, 32'd1);
    step(); s_ack = 1'b0; req1(1'b0, 1'b0, '0, '0); #3;
    step(); step();

`ifdef SDRAM_ARB_WDT_EN
    // T5: slave never acks; the grant is aborted on its eighth cycle.
    step(); req0(1'b1, 1'b0, 32'h600, '0); #3;
    for (int i = 1; i <= 8; i++) begin
      step(); #3;
      chk("t5_stb", {31'd0, s_stb}, 32'd1);
      chk("t5_err", {31'd0, m0_err}, (i == 8) ? 32'd1 : 32'd0);
      chk("t5_err1", {31'd0, m1_err}, 32'd0);
    end
    step(); req0(1'b0, 1'b0, '0, '0); #3;
    chk("t5_drop", {31'd0, s_stb}, 32'd0);
    chk("t5_err_end", {31'd0, m0_err}, 32'd0);
    step(); step();
`endif

    // T6: asynchronous reset mid-grant, then a normal tie after release.
    step(); req0(1'b1, 1'b0, 32'h700, '0); #3;
    step(); #3;
    chk("t6_granted", {31'd0, s_stb}, 32'd1);
    step(); #1; s_ack = 1'b1; rst_n = 1'b0; #2;
    chk("t6_rst_bus", {29'd0, s_cyc, s_stb, s_we}, 32'd0);
    chk("t6_rst_adr", s_adr, 32'd0);
    chk("t6_rst_ack", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    step(); s_ack = 1'b0; rst_n = 1'b1; req1(1'b1, 1'b0, 32'h800, '0); #3;
    chk("t6_idle", {31'd0, s_stb}, 32'd0);
    step(); s_ack = 1'b1; s_rdat = 32'h7777_0000; #3;
    chk("t6_tie_adr", s_adr, 32'h700);
    chk("t6_ack",     {31'd0, m0_ack}, 32'd1);
    chk("t6_dat",     m0_rdat, 32'h7777_0000);
    step(); s_ack = 1'b0; req0(1'b0, 1'b0, '0, '0); req1(1'b0, 1'b0, '0, '0); #3;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
